// File: rtl/hazard_controller_pkg.sv
// Shared pipeline definitions: hazard-controller state encoding, default
// sizing constants and the load-use hazard predicate. The forwarding unit
// imports the same package.
package hazard_controller_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LUSTALL = 2'd1,
        MEMWAIT = 2'd2,
        FAULT   = 2'd3
    } hz_state_e;

    localparam int DEF_TIMEOUT = 255;
    localparam int DEF_CNTW    = 16;
    localparam int WAITW       = 8;

    // A load in ID/EX feeds an operand the IF/ID instruction needs next cycle.
    // A store's rt is exempt: its data is forwarded late, in MEM.
    function automatic logic load_use(input logic       memrd,
                                      input logic [4:0] xrt,
                                      input logic [4:0] rs,
                                      input logic [4:0] rt,
                                      input logic       usesrt,
                                      input logic       memwr);
        return memrd && (xrt != 5'd0) &&
               ((xrt == rs) || ((xrt == rt) && usesrt && !memwr));
    endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline <-> hazard controller bundle. master = pipeline side,
// slave = hazard controller side.
interface hazard_controller_if #(
    parameter int CNTW = hazard_controller_pkg::DEF_CNTW
);
    logic            idexmemrd;
    logic [4:0]      idexrt;
    logic [4:0]      ifidrs;
    logic [4:0]      ifidrt;
    logic            ifidusesrt;
    logic            ifidmemwr;
    logic            exbranchtaken;
    logic            dmemreq;
    logic            dmemready;

    logic            pcwr;
    logic            ifidwr;
    logic            idexwr;
    logic            exmemwr;
    logic            ifidflush;
    logic            idexflush;
    logic            memwbbubble;
    logic            memerr;
    logic [CNTW-1:0] stallcnt;
    logic [CNTW-1:0] flushcnt;

    modport master (
        output idexmemrd, idexrt, ifidrs, ifidrt, ifidusesrt, ifidmemwr,
               exbranchtaken, dmemreq, dmemready,
        input  pcwr, ifidwr, idexwr, exmemwr, ifidflush, idexflush,
               memwbbubble, memerr, stallcnt, flushcnt
    );

    modport slave (
        input  idexmemrd, idexrt, ifidrs, ifidrt, ifidusesrt, ifidmemwr,
               exbranchtaken, dmemreq, dmemready,
        output pcwr, ifidwr, idexwr, exmemwr, ifidflush, idexflush,
               memwbbubble, memerr, stallcnt, flushcnt
    );
endinterface

// File: rtl/hazard_controller_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Count up on inc, hold at all-ones, synchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != {W{1'b1}}))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, data-memory
// freeze with timeout fault, plus stall/flush performance counters.
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNTW    = DEF_CNTW
) (
    input  logic                clk,
    input  logic                rst,
    hazard_controller_if.slave  hz
);

    localparam logic [WAITW-1:0] TO_LIM = WAITW'(TIMEOUT);

    hz_state_e        state_q, state_d;
    logic [WAITW-1:0] wait_q, wait_d;
    logic             memerr_q;
    logic             fault_set;
    logic             frz, luhaz;

    logic pcwr, ifidwr, idexwr, exmemwr;
    logic ifidflush, idexflush, memwbbubble;

    assign frz   = hz.dmemreq && !hz.dmemready;
    assign luhaz = load_use(hz.idexmemrd, hz.idexrt, hz.ifidrs, hz.ifidrt,
                            hz.ifidusesrt, hz.ifidmemwr);

    // State, dmem wait counter and sticky fault flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            wait_q   <= '0;
            memerr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            memerr_q <= memerr_q | fault_set;
        end
    end

    // Next state and stage controls; freeze beats branch beats load-use.
    // MEMWAIT without a pending freeze behaves exactly like RUN.
    always_comb begin
        pcwr        = 1'b1;
        ifidwr      = 1'b1;
        idexwr      = 1'b1;
        exmemwr     = 1'b1;
        ifidflush   = 1'b0;
        idexflush   = 1'b0;
        memwbbubble = 1'b0;
        state_d     = state_q;
        wait_d      = '0;
        fault_set   = 1'b0;

        if (state_q == FAULT) begin
            pcwr        = 1'b0;
            ifidwr      = 1'b0;
            idexwr      = 1'b0;
            exmemwr     = 1'b0;
            memwbbubble = 1'b1;
        end else if (frz) begin
            pcwr        = 1'b0;
            ifidwr      = 1'b0;
            idexwr      = 1'b0;
            exmemwr     = 1'b0;
            memwbbubble = 1'b1;
            wait_d      = wait_q + 1'b1;
            if (wait_d >= TO_LIM) begin
                state_d   = FAULT;
                fault_set = 1'b1;
            end else begin
                state_d   = MEMWAIT;
            end
        end else if (hz.exbranchtaken) begin
            ifidflush = 1'b1;
            idexflush = 1'b1;
            state_d   = RUN;
        end else if (luhaz && (state_q != LUSTALL)) begin
            // One bubble per hazard: the repeat in LUSTALL is masked.
            pcwr      = 1'b0;
            ifidwr    = 1'b0;
            idexflush = 1'b1;
            state_d   = LUSTALL;
        end else begin
            state_d   = RUN;
        end
    end

    sat_counter #(.W(CNTW)) u_stallcnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (!pcwr),
        .cnt (hz.stallcnt)
    );

    sat_counter #(.W(CNTW)) u_flushcnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (ifidflush),
        .cnt (hz.flushcnt)
    );

    assign hz.pcwr        = pcwr;
    assign hz.ifidwr      = ifidwr;
    assign hz.idexwr      = idexwr;
    assign hz.exmemwr     = exmemwr;
    assign hz.ifidflush   = ifidflush;
    assign hz.idexflush   = idexflush;
    assign hz.memwbbubble = memwbbubble;
    assign hz.memerr      = memerr_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: two instances (default sizing, and
// TIMEOUT=4/CNTW=4) driven with identical stimulus. Directed table, corner
// sequences and random traffic, all checked against a cycle model.
module tb_hazard_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_controller_if #(.CNTW(16)) bus ();
    hazard_controller_if #(.CNTW(4))  sbus ();

    hazard_controller #(.TIMEOUT(255), .CNTW(16)) u_main (.clk(clk), .rst(rst), .hz(bus));
    hazard_controller #(.TIMEOUT(4),   .CNTW(4))  u_small (.clk(clk), .rst(rst), .hz(sbus));

    typedef struct {
        logic       memrd;
        logic [4:0] xrt, rs, rt;
        logic       usesrt, memwr, br, dreq, drdy;
    } in_t;

    // ctl bit order: {pcwr, ifidwr, idexwr, exmemwr, ifidflush, idexflush, memwbbubble}
    typedef struct {
        in_t        i;
        logic [6:0] ctl;
        int         stall;
        int         flush;
    } vec_t;

    typedef struct {
        int waitc;
        bit fault;
        bit masked;   // previous cycle inserted a load-use bubble
        int stalls;
        int flushes;
        int timeout;
        int cmax;
    } mdl_t;

    localparam logic [6:0] C_DEF = 7'b1111000;
    localparam logic [6:0] C_FRZ = 7'b0000001;
    localparam logic [6:0] C_BR  = 7'b1111110;
    localparam logic [6:0] C_LU  = 7'b0011010;

    int   nerr = 0;
    int   nchk = 0;
    mdl_t m[2];
    vec_t tbl[13];
    in_t  idle;

    function automatic in_t mk(bit memrd, int xrt, int rs, int rt, bit usesrt,
                               bit memwr, bit br, bit dreq, bit drdy);
        in_t r;
        r.memrd = memrd; r.xrt = 5'(xrt); r.rs = 5'(rs); r.rt = 5'(rt);
        r.usesrt = usesrt; r.memwr = memwr; r.br = br; r.dreq = dreq; r.drdy = drdy;
        return r;
    endfunction

    // Behaviour straight from the rules: fault sticks; freeze wins, then
    // branch, then a load-use hazard unless one was just bubbled.
    function automatic void mdl_eval(input mdl_t s, input in_t i,
                                     output logic [6:0] ctl, output mdl_t n);
        bit frz, haz;
        n   = s;
        frz = i.dreq && !i.drdy;
        haz = i.memrd && (i.xrt != 0) &&
              ((i.xrt == i.rs) || ((i.xrt == i.rt) && i.usesrt && !i.memwr));
        ctl = C_DEF;
        n.masked = 0;
        if (s.fault) ctl = C_FRZ;
        else if (frz) begin
            ctl = C_FRZ;
            n.waitc = s.waitc + 1;
            if (n.waitc >= s.timeout) n.fault = 1;
        end
        else if (i.br) ctl = C_BR;
        else if (haz && !s.masked) begin
            ctl = C_LU;
            n.masked = 1;
        end
        if (!frz) n.waitc = 0;
        if (!ctl[6] && n.stalls < s.cmax) n.stalls++;
        if (ctl[2] && n.flushes < s.cmax) n.flushes++;
    endfunction

    function automatic void mdl_clear(int k);
        m[k].waitc = 0; m[k].fault = 0; m[k].masked = 0;
        m[k].stalls = 0; m[k].flushes = 0;
    endfunction

    function automatic logic [6:0] obs_ctl(int k);
        if (k == 0)
            return {bus.pcwr, bus.ifidwr, bus.idexwr, bus.exmemwr,
                    bus.ifidflush, bus.idexflush, bus.memwbbubble};
        return {sbus.pcwr, sbus.ifidwr, sbus.idexwr, sbus.exmemwr,
                sbus.ifidflush, sbus.idexflush, sbus.memwbbubble};
    endfunction

    function automatic int obs_stall(int k);
        return (k == 0) ? int'(bus.stallcnt) : int'(sbus.stallcnt);
    endfunction

    function automatic int obs_flush(int k);
        return (k == 0) ? int'(bus.flushcnt) : int'(sbus.flushcnt);
    endfunction

    function automatic int obs_err(int k);
        return (k == 0) ? int'(bus.memerr) : int'(sbus.memerr);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic drive(input in_t i);
        bus.idexmemrd = i.memrd;  sbus.idexmemrd = i.memrd;
        bus.idexrt = i.xrt;       sbus.idexrt = i.xrt;
        bus.ifidrs = i.rs;        sbus.ifidrs = i.rs;
        bus.ifidrt = i.rt;        sbus.ifidrt = i.rt;
        bus.ifidusesrt = i.usesrt; sbus.ifidusesrt = i.usesrt;
        bus.ifidmemwr = i.memwr;  sbus.ifidmemwr = i.memwr;
        bus.exbranchtaken = i.br; sbus.exbranchtaken = i.br;
        bus.dmemreq = i.dreq;     sbus.dmemreq = i.dreq;
        bus.dmemready = i.drdy;   sbus.dmemready = i.drdy;
    endtask

    // Drive on the falling edge, let combinational outputs settle.
    task automatic apply(input in_t i);
        @(negedge clk);
        drive(i);
        #1;
    endtask

    // Compare both instances with the model, then advance the model.
    task automatic mcheck(input in_t i);
        for (int k = 0; k < 2; k++) begin
            logic [6:0] ec;
            mdl_t       nx;
            string      tg;
            tg = (k == 0) ? "main" : "small";
            mdl_eval(m[k], i, ec, nx);
            check({tg, " ctl"},      int'(obs_ctl(k)), int'(ec));
            check({tg, " memerr"},   obs_err(k),       int'(m[k].fault));
            check({tg, " stallcnt"}, obs_stall(k),     m[k].stalls);
            check({tg, " flushcnt"}, obs_flush(k),     m[k].flushes);
            m[k] = nx;
        end
    endtask

    task automatic cycle(input in_t i);
        apply(i);
        mcheck(i);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(idle);
        #1;
        for (int k = 0; k < 2; k++) begin
            check("reset ctl",      int'(obs_ctl(k)), int'(C_DEF));
            check("reset memerr",   obs_err(k),   0);
            check("reset stallcnt", obs_stall(k), 0);
            check("reset flushcnt", obs_flush(k), 0);
            mdl_clear(k);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        in_t frzi, rdyi, lui;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        frzi = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
        rdyi = mk(0, 0, 0, 0, 0, 0, 0, 1, 1);
        lui  = mk(1, 5, 5, 0, 0, 0, 0, 0, 0);
        m[0].timeout = 255; m[0].cmax = 65535;
        m[1].timeout = 4;   m[1].cmax = 15;
        mdl_clear(0);
        mdl_clear(1);

        tbl[0]  = '{idle,                            C_DEF, 0, 0};
        tbl[1]  = '{lui,                             C_LU,  0, 0};
        tbl[2]  = '{lui,                             C_DEF, 1, 0};
        tbl[3]  = '{idle,                            C_DEF, 1, 0};
        tbl[4]  = '{mk(1, 5, 3, 5, 0, 1, 0, 0, 0),   C_DEF, 1, 0};
        tbl[5]  = '{mk(1, 5, 3, 5, 1, 1, 0, 0, 0),   C_DEF, 1, 0};
        tbl[6]  = '{mk(1, 0, 0, 0, 1, 0, 0, 0, 0),   C_DEF, 1, 0};
        tbl[7]  = '{mk(1, 7, 1, 7, 1, 0, 0, 0, 0),   C_LU,  1, 0};
        tbl[8]  = '{mk(0, 0, 0, 0, 0, 0, 1, 0, 0),   C_BR,  2, 0};
        tbl[9]  = '{mk(1, 5, 5, 0, 0, 0, 1, 0, 0),   C_BR,  2, 1};
        tbl[10] = '{mk(1, 5, 5, 0, 0, 0, 1, 1, 0),   C_FRZ, 2, 2};
        tbl[11] = '{mk(1, 5, 5, 0, 0, 0, 0, 1, 1),   C_LU,  3, 2};
        tbl[12] = '{idle,                            C_DEF, 4, 2};

        drive(idle);
        do_reset();

        // Directed table: load-use, store exemption, r0, branch, freeze priority.
        for (int v = 0; v < 13; v++) begin
            apply(tbl[v].i);
            check($sformatf("tbl[%0d] ctl", v), int'(obs_ctl(0)), int'(tbl[v].ctl));
            check($sformatf("tbl[%0d] stallcnt", v), obs_stall(0), tbl[v].stall);
            check($sformatf("tbl[%0d] flushcnt", v), obs_flush(0), tbl[v].flush);
            mcheck(tbl[v].i);
        end

        // Three frozen cycles, release on the fourth.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            apply(frzi);
            check("memwait frozen ctl", int'(obs_ctl(0)), int'(C_FRZ));
            mcheck(frzi);
        end
        apply(rdyi);
        check("memwait release ctl", int'(obs_ctl(0)), int'(C_DEF));
        mcheck(rdyi);
        apply(idle);
        check("memwait stallcnt", obs_stall(0), 3);
        check("memwait small stallcnt", obs_stall(1), 3);
        mcheck(idle);

        // Timeout on the TIMEOUT=4 instance, then asynchronous reset.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            apply(frzi);
            check("pre-fault memerr", obs_err(1), 0);
            check("pre-fault ctl", int'(obs_ctl(1)), int'(C_FRZ));
            mcheck(frzi);
        end
        apply(frzi);
        check("fault memerr", obs_err(1), 1);
        check("fault ctl", int'(obs_ctl(1)), int'(C_FRZ));
        check("main no fault", obs_err(0), 0);
        mcheck(frzi);
        apply(rdyi);
        check("fault held memerr", obs_err(1), 1);
        check("fault held ctl", int'(obs_ctl(1)), int'(C_FRZ));
        mcheck(rdyi);
        @(negedge clk);
        #2;
        drive(idle);
        rst = 1'b1;
        #1;
        check("async rst memerr", obs_err(1), 0);
        check("async rst ctl", int'(obs_ctl(1)), int'(C_DEF));
        check("async rst stallcnt", obs_stall(1), 0);
        mdl_clear(0);
        mdl_clear(1);
        @(negedge clk);
        rst = 1'b0;

        // Twenty load-use stalls: CNTW=4 saturates at 15.
        do_reset();
        for (int c = 0; c < 40; c++) cycle(lui);
        apply(idle);
        check("sat small stallcnt", obs_stall(1), 15);
        check("sat main stallcnt", obs_stall(0), 20);
        mcheck(idle);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            in_t r;
            if ($urandom_range(0, 199) == 0) do_reset();
            r.memrd  = 1'($urandom_range(0, 1));
            r.xrt    = 5'($urandom_range(0, 3));
            r.rs     = 5'($urandom_range(0, 3));
            r.rt     = 5'($urandom_range(0, 3));
            r.usesrt = 1'($urandom_range(0, 1));
            r.memwr  = 1'($urandom_range(0, 1));
            r.br     = ($urandom_range(0, 5) == 0);
            r.dreq   = ($urandom_range(0, 2) == 0);
            r.drdy   = 1'($urandom_range(0, 1));
            cycle(r);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
